cpu_cycle_sequencer: RTL and testbench

Multi-cycle control sequencer for the CPU datapath. It steps each instruction through FETCH, DECODE, EXECUTE, an optional MEM phase and WRITEBACK. In each phase it drives the load strobes for the IR, PC, MAR, MDR and register file. It handshakes with instruction and data memories that may insert wait states, and it enters a sticky fault state on memory timeout. It sits between the Control_Unit decode outputs and the datapath registers, replacing the always-on single-cycle strobes.

---
 rtl/cpu_cycle_sequencer.sv | 123 ++++++++++++
 tb/tb_cpu_cycle_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_cycle_sequencer.sv
// Multi-cycle instruction sequencer: steps FETCH/DECODE/EXECUTE/[MEM]/WRITEBACK,
// drives datapath load strobes, handshakes with wait-stated memories, faults on timeout.
module cpu_cycle_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 halt_req,
  input  logic                 dec_mem_read,
  input  logic                 dec_mem_write,
  input  logic                 dec_reg_write,
  input  logic                 dec_jump,
  input  logic                 dec_branch_taken,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 ir_load,
  output logic                 pc_inc,
  output logic                 pc_load,
  output logic                 mar_load,
  output logic                 mdr_load,
  output logic                 reg_write,
  output logic                 mem_write,
  output logic [2:0]           state,
  output logic                 busy,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] retired_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEM       = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_FAULT     = 3'd7;

  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WAIT_LIMIT = 32'(TIMEOUT_CYCLES - 1);

  logic [2:0]           r_state;
  logic [2:0]           w_next;
  logic [31:0]          r_wait;
  logic                 r_rd, r_wr, r_rw, r_jmp, r_br;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_busy, r_fault;
  logic                 w_expired;
  logic                 w_waiting;
  logic                 w_redirect;

  // The last permitted wait cycle faults only if ready is still low in it.
  assign w_expired  = TIMEOUT_EN && (r_wait == WAIT_LIMIT);
  assign w_waiting  = ((r_state == S_FETCH) && !imem_ready) ||
                      ((r_state == S_MEM) && !dmem_ready);
  assign w_redirect = r_jmp | r_br;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (run) w_next = S_FETCH;
      S_FETCH:     if (imem_ready) w_next = S_DECODE;
                   else if (w_expired) w_next = S_FAULT;
      S_DECODE:    w_next = S_EXECUTE;
      S_EXECUTE:   w_next = (dec_mem_read | dec_mem_write) ? S_MEM : S_WRITEBACK;
      S_MEM:       if (dmem_ready) w_next = S_WRITEBACK;
                   else if (w_expired) w_next = S_FAULT;
      S_WRITEBACK: w_next = halt_req ? S_IDLE : S_FETCH;
      S_FAULT:     w_next = S_FAULT;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_rw    <= 1'b0;
      r_jmp   <= 1'b0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE) && (w_next != S_FAULT);
      r_fault <= (w_next == S_FAULT);
      if ((w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM)))
        r_wait <= '0;
      else if (w_waiting)
        r_wait <= r_wait + 32'd1;
      if (r_state == S_EXECUTE) begin
        r_rd  <= dec_mem_read;
        r_wr  <= dec_mem_write;
        r_rw  <= dec_reg_write;
        r_jmp <= dec_jump;
        r_br  <= dec_branch_taken;
      end
      if (r_state == S_WRITEBACK)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // A latched write suppresses the MDR capture even when a read is also latched.
  assign imem_req      = (r_state == S_FETCH);
  assign dmem_req      = (r_state == S_MEM);
  assign ir_load       = (r_state == S_FETCH) && imem_ready;
  assign mar_load      = (r_state == S_EXECUTE) && (dec_mem_read | dec_mem_write);
  assign mdr_load      = (r_state == S_MEM) && dmem_ready && r_rd && !r_wr;
  assign mem_write     = (r_state == S_MEM) && r_wr;
  assign reg_write     = (r_state == S_WRITEBACK) && r_rw;
  assign pc_load       = (r_state == S_WRITEBACK) && w_redirect;
  assign pc_inc        = (r_state == S_WRITEBACK) && !w_redirect;
  assign state         = r_state;
  assign busy          = r_busy;
  assign fault         = r_fault;
  assign retired_count = r_cnt;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Randomized bench for cpu_cycle_sequencer: each instruction descriptor is expanded
// into its expected per-cycle phase trace and compared against the design.
module tb_cpu_cycle_sequencer;

  localparam int TO = 4;
  localparam int CW = 4;

  localparam logic [8:0] IREQ = 9'h100;
  localparam logic [8:0] DREQ = 9'h080;
  localparam logic [8:0] IRL  = 9'h040;
  localparam logic [8:0] PCI  = 9'h020;
  localparam logic [8:0] PCL  = 9'h010;
  localparam logic [8:0] MAR  = 9'h008;
  localparam logic [8:0] MDR  = 9'h004;
  localparam logic [8:0] RW   = 9'h002;
  localparam logic [8:0] MW   = 9'h001;

  logic clk = 1'b0;
  logic reset, run, halt_req;
  logic dec_mem_read, dec_mem_write, dec_reg_write, dec_jump, dec_branch_taken;
  logic imem_ready, dmem_ready;
  logic imem_req, dmem_req, ir_load, pc_inc, pc_load, mar_load, mdr_load;
  logic reg_write, mem_write, busy, fault;
  logic [2:0] state;
  logic [CW-1:0] retired_count;

  int n_chk = 0;
  int n_err = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  cpu_cycle_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .halt_req(halt_req),
    .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_reg_write(dec_reg_write), .dec_jump(dec_jump),
    .dec_branch_taken(dec_branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .mdr_load(mdr_load), .reg_write(reg_write), .mem_write(mem_write),
    .state(state), .busy(busy), .fault(fault), .retired_count(retired_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs that the current phase must ignore get random values.
  task automatic rnd_inputs();
    run              = 1'($urandom);
    halt_req         = 1'($urandom);
    dec_mem_read     = 1'($urandom);
    dec_mem_write    = 1'($urandom);
    dec_reg_write    = 1'($urandom);
    dec_jump         = 1'($urandom);
    dec_branch_taken = 1'($urandom);
    imem_ready       = 1'($urandom);
    dmem_ready       = 1'($urandom);
  endtask

  task automatic step(input string tag, input logic [2:0] st, input logic [8:0] sb);
    logic [13:0] exp;
    logic [13:0] obs;
    exp = {sb, st, (st >= 3'd1 && st <= 3'd5), (st == 3'd7)};
    @(negedge clk);
    obs = {imem_req, dmem_req, ir_load, pc_inc, pc_load, mar_load, mdr_load,
           reg_write, mem_write, state, busy, fault};
    chk(tag, {18'd0, obs}, {18'd0, exp});
    chk({tag, "_cnt"}, {28'd0, retired_count}, 32'(m_cnt));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    rnd_inputs();
    run = r;
    step("idle", 3'd0, 9'h000);
  endtask

  task automatic fetch_phase(input int wi);
    for (int k = 0; k <= wi; k++) begin
      rnd_inputs();
      imem_ready = (k == wi);
      step("fetch", 3'd1, IREQ | ((k == wi) ? IRL : 9'h000));
    end
  endtask

  task automatic front(input int wi, input logic rd, input logic wr, input logic rw,
                       input logic j, input logic b);
    fetch_phase(wi);
    rnd_inputs();
    step("decode", 3'd2, 9'h000);
    rnd_inputs();
    dec_mem_read = rd; dec_mem_write = wr; dec_reg_write = rw;
    dec_jump = j; dec_branch_taken = b;
    step("exec", 3'd3, (rd | wr) ? MAR : 9'h000);
  endtask

  task automatic run_instr(input logic rd, input logic wr, input logic rw, input logic j,
                           input logic b, input int wi, input int wd, input logic halt);
    front(wi, rd, wr, rw, j, b);
    if (rd | wr) begin
      for (int k = 0; k <= wd; k++) begin
        rnd_inputs();
        dmem_ready = (k == wd);
        step("mem", 3'd4, DREQ | (wr ? MW : 9'h000) |
             ((k == wd && rd && !wr) ? MDR : 9'h000));
      end
    end
    rnd_inputs();
    halt_req = halt;
    step("wb", 3'd5, (rw ? RW : 9'h000) | ((j | b) ? PCL : PCI));
    m_cnt = (m_cnt + 1) % (1 << CW);
  endtask

  task automatic rand_instr(input logic halt);
    run_instr(($urandom % 3) == 0, ($urandom % 3) == 0, 1'($urandom),
              ($urandom % 4) == 0, ($urandom % 4) == 0,
              int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)), halt);
  endtask

  task automatic apply_reset(input string tag, input logic [2:0] st, input logic [8:0] sb);
    rnd_inputs();
    reset = 1'b1;
    step(tag, st, sb);
    reset = 1'b0;
    m_cnt = 0;
  endtask

  initial begin
    rnd_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    step("rst", 3'd0, 9'h000);
    reset = 1'b0;
    idle(1'b0);
    idle(1'b1);

    // Directed opening instructions, then random ones, 17 retirements in all.
    run_instr(0, 0, 1, 0, 0, 0, 0, 0);
    run_instr(1, 0, 1, 0, 0, 0, 3, 0);
    run_instr(0, 1, 0, 0, 0, 1, 0, 0);
    run_instr(0, 0, 0, 1, 0, 0, 0, 0);
    run_instr(1, 1, 1, 0, 1, TO - 1, TO - 1, 0);
    for (int i = 5; i < 17; i++) rand_instr(i == 16);
    chk("wrap17", {28'd0, retired_count}, 32'd1);
    idle(1'b0);
    idle(1'b1);

    for (int i = 0; i < 40; i++) begin
      logic h;
      h = (i != 39) && (($urandom % 5) == 0);
      rand_instr(h);
      if (h) begin
        idle(1'b0);
        idle(1'b1);
      end
    end

    // Data-memory timeout: ready never arrives in MEM.
    front(0, 1, 0, 1, 0, 0);
    for (int k = 0; k < TO; k++) begin
      rnd_inputs();
      dmem_ready = 1'b0;
      step("mem_wait", 3'd4, DREQ);
    end
    for (int k = 0; k < 3; k++) begin
      rnd_inputs();
      step("mem_fault", 3'd7, 9'h000);
    end
    apply_reset("fault_rst", 3'd7, 9'h000);
    idle(1'b0);
    idle(1'b1);

    // Instruction-memory timeout with run held high in FAULT.
    for (int k = 0; k < TO; k++) begin
      rnd_inputs();
      imem_ready = 1'b0;
      step("fetch_wait", 3'd1, IREQ);
    end
    for (int k = 0; k < 3; k++) begin
      rnd_inputs();
      run = 1'b1;
      step("if_fault", 3'd7, 9'h000);
    end
    apply_reset("fault_rst2", 3'd7, 9'h000);
    idle(1'b0);
    idle(1'b1);

    // Reset while a store holds mem_write high.
    run_instr(0, 0, 1, 0, 0, 0, 0, 0);
    front(0, 0, 1, 0, 0, 0);
    rnd_inputs();
    dmem_ready = 1'b0;
    reset = 1'b1;
    step("mem_rst", 3'd4, DREQ | MW);
    reset = 1'b0;
    m_cnt = 0;
    idle(1'b0);
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
